// File: rtl/frame_wb_pkg.sv
// Shared types and constants for the frame write-back controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Contents: controller state enum, default buffer bases, word-select constants.
package frame_wb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    SWAP  = 3'd4
  } state_e;

  localparam int unsigned DEF_BASE0 = 0;
  localparam int unsigned DEF_BASE1 = 128;

  // Which half of the current FIFO head the writer emits next.
  localparam logic WORD_LO = 1'b0;
  localparam logic WORD_HI = 1'b1;

endpackage

// File: rtl/row_fifo.sv
// Two-entry row buffer between the coprocessor strobe and the RAM writer.
// Latency: a pushed row is visible on head_dat the cycle after the push edge.
// Backpressure: a push while full is accepted only if a pop happens in the same cycle, otherwise discarded.
// Ports: clk/reset (async active-low), push/push_dat in, pop in, head_dat/full/empty out.
module row_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign full     = (cnt_q == 2'd2);
  assign empty    = (cnt_q == 2'd0);
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_writeback_ctrl.sv
// Sequences one coprocessor frame into a double-buffered RAM, two 32-bit writes per 64-bit row.
// Latency: row strobed at edge t -> low word write registered at t+1, high word at t+2; 1 row / 2 cycles.
// Backpressure: none upstream; rows that find the 2-entry buffer full (no same-cycle pop) are dropped and flagged.
// Ports: start/cop_start handshake, cop_line/cop_row/cop_done from coprocessor, wr_en/wr_addr/wr_data to RAM,
//        disp_base to VGA reader, frame_ready/busy/overflow/rows_written status.
module frame_writeback_ctrl
  import frame_wb_pkg::*;
#(
  parameter int          ROW_W  = 64,
  parameter int          WORD_W = 32,
  parameter int          ROWS   = 64,
  parameter int          ADDR_W = 12,
  parameter int unsigned BASE0  = DEF_BASE0,
  parameter int unsigned BASE1  = DEF_BASE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              cop_start,
  input  logic              cop_line,
  input  logic [ROW_W-1:0]  cop_row,
  input  logic              cop_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic [ADDR_W-1:0] disp_base,
  output logic              frame_ready,
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        rows_written
);

  localparam logic [ADDR_W-1:0] BASE0_A = ADDR_W'(BASE0);
  localparam logic [ADDR_W-1:0] BASE1_A = ADDR_W'(BASE1);
  localparam logic [6:0]        ROWS_C  = 7'(ROWS);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic [ADDR_W-1:0]   disp_base_q, disp_base_d;
  logic                overflow_q, overflow_d;
  logic [6:0]          rows_written_q, rows_written_d;
  logic [6:0]          rows_acc_q, rows_acc_d;
  logic                phase_q, phase_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ROW_W-1:0]    fifo_head;
  logic [ADDR_W-1:0]   row_addr;
  logic                writer_on;

  row_fifo #(.W(ROW_W)) u_row_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (cop_row),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign row_addr  = target_q + ADDR_W'({rows_written_q, 1'b0});
  assign writer_on = (state_q == RUN) || (state_q == DRAIN);

  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    disp_base_d    = disp_base_q;
    overflow_d     = overflow_q;
    rows_written_d = rows_written_q;
    rows_acc_d     = rows_acc_q;
    phase_d        = phase_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    fifo_pop       = 1'b0;
    fifo_push      = 1'b0;

    // Writer: the row stays at the FIFO head for both words and is popped
    // on the high-word cycle, so a full FIFO can only take a row then.
    if (writer_on && !fifo_empty) begin
      wr_en_d = 1'b1;
      if (phase_q == WORD_LO) begin
        wr_addr_d = row_addr;
        wr_data_d = fifo_head[WORD_W-1:0];
        phase_d   = WORD_HI;
      end else begin
        wr_addr_d      = row_addr + ADDR_W'(1);
        wr_data_d      = fifo_head[WORD_W +: WORD_W];
        phase_d        = WORD_LO;
        fifo_pop       = 1'b1;
        rows_written_d = rows_written_q + 7'd1;
      end
    end

    // Row intake: only in RUN and only until a full frame has been accepted.
    if (cop_line && (state_q == RUN) && (rows_acc_q < ROWS_C) && (!fifo_full || fifo_pop)) begin
      fifo_push  = 1'b1;
      rows_acc_d = rows_acc_q + 7'd1;
    end
    if (cop_line && (((state_q == RUN) && !fifo_push) || (state_q == DRAIN))) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = START;
          overflow_d     = 1'b0;
          rows_written_d = 7'd0;
          rows_acc_d     = 7'd0;
          target_d       = (disp_base_q == BASE0_A) ? BASE1_A : BASE0_A;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (cop_done || (rows_written_q == ROWS_C)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && (phase_q == WORD_LO)) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        disp_base_d = target_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      target_q       <= BASE1_A;
      disp_base_q    <= BASE0_A;
      overflow_q     <= 1'b0;
      rows_written_q <= 7'd0;
      rows_acc_q     <= 7'd0;
      phase_q        <= WORD_LO;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      disp_base_q    <= disp_base_d;
      overflow_q     <= overflow_d;
      rows_written_q <= rows_written_d;
      rows_acc_q     <= rows_acc_d;
      phase_q        <= phase_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
    end
  end

  assign cop_start    = (state_q == START);
  assign frame_ready  = (state_q == SWAP);
  assign busy         = (state_q != IDLE);
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign disp_base    = disp_base_q;
  assign overflow     = overflow_q;
  assign rows_written = rows_written_q;

endmodule
